// File: rtl/brq_pkg.sv
// Shared types for the branch resolve queue.
// Entry record and the default queue depth.
package brq_pkg;

  localparam int BRQ_DEPTH = 16;

  typedef struct packed {
    logic        valid;
    logic        resolved;
    logic [31:0] pc;
    logic        pred;
    logic        taken;
  } brq_entry_t;

endpackage

// File: rtl/branch_resolve_queue.sv
// Circular queue of in-flight predicted branches: alloc at tail,
// out-of-order resolve by tag, in-order commit feeding predictor training.
// Ports: alloc_* (decode), resolve_* (execute), mispredict*, commit_ready,
// rob_commit, flush, branch_commit/pc/taken (predictor update).
// Optional: BRQ_PERF_EN adds perf_branches / perf_mispredicts counters.
module branch_resolve_queue
  import brq_pkg::*;
#(
  parameter int DEPTH = BRQ_DEPTH,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [31:0]      alloc_pc,
  input  logic             alloc_pred,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_taken,
  output logic             mispredict,
  output logic [TAG_W-1:0] mispredict_tag,
  output logic             commit_ready,
  input  logic             rob_commit,
  input  logic             flush,
  output logic             branch_commit,
  output logic [31:0]      branch_pc,
  output logic             branch_taken
`ifdef BRQ_PERF_EN
  ,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispredicts
`endif
);

  localparam logic [TAG_W:0] FULL = (TAG_W+1)'(DEPTH);

  brq_entry_t       ent [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;

  logic alloc_ok;
  logic commit_ok;
  logic resolve_ok;
  logic res_mis;

  assign alloc_ready  = !rst && !flush && (count != FULL);
  assign alloc_tag    = rst ? '0 : tail;
  // Flush does not gate commit: an older branch retiring is final.
  assign commit_ready = !rst && ent[head].valid && ent[head].resolved;

  assign alloc_ok   = alloc_valid && alloc_ready;
  assign commit_ok  = rob_commit && commit_ready;
  assign resolve_ok = resolve_valid && !flush &&
                      ent[resolve_tag].valid &&
                      !ent[resolve_tag].resolved;
  assign res_mis    = resolve_ok &&
                      (resolve_taken != ent[resolve_tag].pred);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      mispredict     <= 1'b0;
      mispredict_tag <= '0;
      branch_commit  <= 1'b0;
      branch_pc      <= '0;
      branch_taken   <= 1'b0;
    end else begin
      mispredict     <= res_mis;
      mispredict_tag <= res_mis ? resolve_tag : '0;
      branch_commit  <= commit_ok;
      branch_pc      <= commit_ok ? ent[head].pc : '0;
      branch_taken   <= commit_ok && ent[head].taken;
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (resolve_ok) begin
          ent[resolve_tag].resolved <= 1'b1;
          ent[resolve_tag].taken    <= resolve_taken;
        end
        if (commit_ok) begin
          ent[head].valid <= 1'b0;
          head            <= head + 1'b1;
        end
        if (alloc_ok) begin
          ent[tail] <= '{valid:    1'b1,
                         resolved: 1'b0,
                         pc:       alloc_pc,
                         pred:     alloc_pred,
                         taken:    1'b0};
          tail      <= tail + 1'b1;
        end
        unique case ({alloc_ok, commit_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

`ifdef BRQ_PERF_EN
  // Cleared by rst only; flush leaves the totals alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else if (commit_ok) begin
      if (perf_branches != '1)
        perf_branches <= perf_branches + 1'b1;
      if ((ent[head].taken != ent[head].pred) &&
          (perf_mispredicts != '1))
        perf_mispredicts <= perf_mispredicts + 1'b1;
    end
  end
`endif

endmodule
